// File: rtl/codec_ctrl_pkg.sv
// Shared types and the default power-up register table for the CODEC
// command scheduler.
package codec_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } cmd_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } codec_reg_entry_t;

    localparam int CODEC_INIT_TABLE_LEN = 10;

    // Power-up register writes, issued in array order: {addr, data}.
    localparam codec_reg_entry_t CODEC_INIT_TABLE [CODEC_INIT_TABLE_LEN] = '{
        16'h0080, 16'h0101, 16'h023F, 16'h033F, 16'h0415,
        16'h0515, 16'h0600, 16'h070A, 16'h0840, 16'h0901
    };

endpackage

// File: rtl/codec_init_rom.sv
// Combinational init-table lookup. Entries past the built-in table are
// filled with a deterministic {idx, ~idx} pattern so larger INIT_LEN
// values still elaborate; indices at or beyond INIT_LEN read as zero.
module codec_init_rom
    import codec_ctrl_pkg::*;
#(
    parameter int INIT_LEN = 10
) (
    input  logic [7:0]       idx_i,
    output codec_reg_entry_t entry_o
);

    // Table lookup with range guard.
    always_comb begin
        entry_o = '0;
        if (int'(idx_i) < INIT_LEN) begin
            if (int'(idx_i) < CODEC_INIT_TABLE_LEN) begin
                entry_o = CODEC_INIT_TABLE[idx_i[3:0]];
            end else begin
                entry_o = {idx_i, ~idx_i};
            end
        end
    end

endmodule

// File: rtl/codec_cmd_scheduler.sv
// Arbitrates the power-up init sequence and the host register port onto
// the single CODEC command port, one command at a time.
//
// Handshakes:
//   host_req is a level held by the host until host_ack; host_we, host_addr
//   and host_wdata must be stable while host_req is high. host_ack is a
//   one-cycle pulse (first GAP cycle) with host_rdata/host_err valid in
//   that same cycle only. codec_wr_en/codec_rd_en are one-cycle pulses in
//   ISSUE; codec_reg_addr/codec_data_wr hold until the next issue. The
//   controller answers by raising controller_busy, may pulse
//   codec_data_rd_valid while busy, and finishes by dropping busy.
module codec_cmd_scheduler
    import codec_ctrl_pkg::*;
#(
    parameter int INIT_LEN     = 10,
    parameter int BUSY_TIMEOUT = 4096,
    parameter int GAP_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_start,
    output logic       init_busy,
    output logic       init_done,
    output logic       init_error,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       host_err,
    output logic       codec_rd_en,
    output logic       codec_wr_en,
    output logic [7:0] codec_reg_addr,
    output logic [7:0] codec_data_wr,
    input  logic [7:0] codec_data_rd,
    input  logic       codec_data_rd_valid,
    input  logic       controller_busy,
    output logic [2:0] dbg_state_o
);

    localparam int TMO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int IDX_W    = $clog2(INIT_LEN + 1);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    cmd_state_t       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             init_busy_q, init_busy_d;
    logic             init_done_q, init_done_d;
    logic             init_error_q, init_error_d;
    logic             is_init_q, is_init_d;
    logic             we_q, we_d;
    logic             got_data_q, got_data_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             host_ack_q, host_ack_d;
    logic [7:0]       host_rdata_q, host_rdata_d;
    logic             host_err_q, host_err_d;

    logic             start_fresh;
    logic             init_go;
    logic [7:0]       rom_idx;
    codec_reg_entry_t rom_entry;
    logic             done_now;
    logic             err_now;

    // A fresh init_start restarts from entry 0 and beats a host request
    // arriving in the same IDLE cycle.
    assign start_fresh = init_start && !init_busy_q;
    assign init_go     = start_fresh || (init_busy_q && (idx_q < IDX_W'(INIT_LEN)));
    assign rom_idx     = start_fresh ? 8'd0 : 8'(idx_q);

    codec_init_rom #(
        .INIT_LEN (INIT_LEN)
    ) u_rom (
        .idx_i   (rom_idx),
        .entry_o (rom_entry)
    );

    // State and datapath registers; reset drops every output at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tmo_q        <= '0;
            gap_q        <= '0;
            idx_q        <= '0;
            init_busy_q  <= 1'b0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            is_init_q    <= 1'b0;
            we_q         <= 1'b0;
            got_data_q   <= 1'b0;
            rdata_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            host_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            idx_q        <= idx_d;
            init_busy_q  <= init_busy_d;
            init_done_q  <= init_done_d;
            init_error_q <= init_error_d;
            is_init_q    <= is_init_d;
            we_q         <= we_d;
            got_data_q   <= got_data_d;
            rdata_q      <= rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            host_err_q   <= host_err_d;
        end
    end

    // Next-state: arbitration, busy tracking, timeouts, completion, gap.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        idx_d        = idx_q;
        init_busy_d  = init_busy_q;
        init_done_d  = init_done_q;
        init_error_d = init_error_q;
        is_init_d    = is_init_q;
        we_d         = we_q;
        got_data_d   = got_data_q;
        rdata_d      = rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        host_ack_d   = 1'b0;
        host_rdata_d = '0;
        host_err_d   = 1'b0;
        done_now     = 1'b0;
        err_now      = 1'b0;

        if (start_fresh) begin
            init_busy_d  = 1'b1;
            init_done_d  = 1'b0;
            init_error_d = 1'b0;
            idx_d        = '0;
        end

        case (state_q)
            IDLE: begin
                if (init_go || host_req) begin
                    state_d    = ISSUE;
                    tmo_d      = '0;
                    got_data_d = 1'b0;
                    rdata_d    = '0;
                    if (init_go) begin
                        is_init_d = 1'b1;
                        we_d      = 1'b1;
                        addr_d    = rom_entry.addr;
                        wdata_d   = rom_entry.data;
                    end else begin
                        is_init_d = 1'b0;
                        we_d      = host_we;
                        addr_d    = host_addr;
                        wdata_d   = host_wdata;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                tmo_d   = '0;
            end
            WAIT_BUSY: begin
                if (controller_busy) begin
                    state_d = WAIT_DONE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_W'(BUSY_TIMEOUT)) begin
                        done_now = 1'b1;
                        err_now  = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (codec_data_rd_valid) begin
                    rdata_d    = codec_data_rd;
                    got_data_d = 1'b1;
                end
                if (!controller_busy) begin
                    done_now = 1'b1;
                    err_now  = !we_q && !got_data_d;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_W'(BUSY_TIMEOUT)) begin
                        done_now = 1'b1;
                        err_now  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_now) begin
            state_d = GAP;
            gap_d   = '0;
            if (is_init_q) begin
                if (err_now) begin
                    init_busy_d  = 1'b0;
                    init_error_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (idx_d == IDX_W'(INIT_LEN)) begin
                        init_busy_d = 1'b0;
                        init_done_d = 1'b1;
                    end
                end
            end else begin
                host_ack_d   = 1'b1;
                host_rdata_d = we_q ? 8'd0 : rdata_d;
                host_err_d   = err_now;
            end
        end
    end

    assign codec_wr_en    = (state_q == ISSUE) && we_q;
    assign codec_rd_en    = (state_q == ISSUE) && !we_q;
    assign codec_reg_addr = addr_q;
    assign codec_data_wr  = wdata_q;
    assign init_busy      = init_busy_q;
    assign init_done      = init_done_q;
    assign init_error     = init_error_q;
    assign host_ack       = host_ack_q;
    assign host_rdata     = host_rdata_q;
    assign host_err       = host_err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_codec_cmd_scheduler.sv
// Directed bench for codec_cmd_scheduler with a behavioural controller.
module tb_codec_cmd_scheduler;

    logic       clk;
    logic       reset;
    logic       init_start;
    logic       init_busy;
    logic       init_done;
    logic       init_error;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       host_err;
    logic       codec_rd_en;
    logic       codec_wr_en;
    logic [7:0] codec_reg_addr;
    logic [7:0] codec_data_wr;
    logic [7:0] codec_data_rd;
    logic       codec_data_rd_valid;
    logic       controller_busy;
    logic [2:0] dbg_state_o;

    int checks = 0;
    int errors = 0;

    // Expected commands: {is_read, addr, data}.
    logic [16:0] exp_q[$];

    int cyc = 0;
    int cmd_cnt = 0;
    int rd_cnt = 0;
    int ack_cnt = 0;
    int last_issue_cyc = 0;
    int last_ack_cyc = 0;
    logic [7:0] last_rdata = '0;
    logic       last_err = 1'b0;

    int         model_busy_len = 20;
    logic       model_give_valid = 1'b0;
    logic [7:0] model_rd_data = '0;
    int         model_cmd_n = 0;
    int         model_stuck_at = -1;

    codec_cmd_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .init_start          (init_start),
        .init_busy           (init_busy),
        .init_done           (init_done),
        .init_error          (init_error),
        .host_req            (host_req),
        .host_we             (host_we),
        .host_addr           (host_addr),
        .host_wdata          (host_wdata),
        .host_ack            (host_ack),
        .host_rdata          (host_rdata),
        .host_err            (host_err),
        .codec_rd_en         (codec_rd_en),
        .codec_wr_en         (codec_wr_en),
        .codec_reg_addr      (codec_reg_addr),
        .codec_data_wr       (codec_data_wr),
        .codec_data_rd       (codec_data_rd),
        .codec_data_rd_valid (codec_data_rd_valid),
        .controller_busy     (controller_busy),
        .dbg_state_o         (dbg_state_o)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] init_tab(input int i);
        case (i)
            0: init_tab = 16'h0080;
            1: init_tab = 16'h0101;
            2: init_tab = 16'h023F;
            3: init_tab = 16'h033F;
            4: init_tab = 16'h0415;
            5: init_tab = 16'h0515;
            6: init_tab = 16'h0600;
            7: init_tab = 16'h070A;
            8: init_tab = 16'h0840;
            9: init_tab = 16'h0901;
            default: init_tab = 16'h0000;
        endcase
    endfunction

    // Controller model: busy for model_busy_len cycles per command, optional
    // read-data pulse mid-busy, optional silence on one chosen command.
    initial begin
        controller_busy     = 1'b0;
        codec_data_rd_valid = 1'b0;
        codec_data_rd       = '0;
        forever begin
            @(negedge clk);
            if (reset && (codec_wr_en || codec_rd_en)) begin
                model_cmd_n++;
                if (model_cmd_n - 1 != model_stuck_at) begin
                    controller_busy = 1'b1;
                    for (int i = 0; i < model_busy_len; i++) begin
                        @(negedge clk);
                        if (!reset) break;
                        if (model_give_valid && i == model_busy_len / 2) begin
                            codec_data_rd_valid = 1'b1;
                            codec_data_rd       = model_rd_data;
                        end else begin
                            codec_data_rd_valid = 1'b0;
                        end
                    end
                    controller_busy     = 1'b0;
                    codec_data_rd_valid = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every command pulse must match the expected queue.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (codec_wr_en || codec_rd_en) begin
                cmd_cnt++;
                if (codec_rd_en) rd_cnt++;
                last_issue_cyc = cyc;
                check("single_enable", 32'(codec_wr_en & codec_rd_en), 32'd0);
                check("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("cmd", {15'd0, codec_rd_en, codec_reg_addr, codec_data_wr}, {15'd0, e});
                end
            end
            if (host_ack) begin
                ack_cnt++;
                last_rdata   = host_rdata;
                last_err     = host_err;
                last_ack_cyc = cyc;
            end
        end
    end

    task automatic pulse_init();
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
    endtask

    task automatic wait_init_clear(input string tag, input int bound);
        int n = 0;
        while (init_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(init_busy), 32'd0);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((dbg_state_o != 3'd0 || init_busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 32'(dbg_state_o), 32'd0);
    endtask

    task automatic wait_ack(input string tag, input int bound);
        int n = 0;
        while (!host_ack && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(host_ack), 32'd1);
    endtask

    task automatic host_txn(input logic we, input logic [7:0] a, input logic [7:0] d);
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        host_req   = 1'b1;
        wait_ack("host_ack_seen", 600);
        host_req = 1'b0;
        @(negedge clk);
    endtask

    // Directed sequence.
    initial begin
        int c0, a0, ack1, t_err, diff, n;
        reset      = 1'b0;
        init_start = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        repeat (3) @(negedge clk);

        check("rst_wr_en", 32'(codec_wr_en), 32'd0);
        check("rst_rd_en", 32'(codec_rd_en), 32'd0);
        check("rst_addr", 32'(codec_reg_addr), 32'd0);
        check("rst_init_flags", {29'd0, init_busy, init_done, init_error}, 32'd0);
        check("rst_ack", 32'(host_ack), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_rst", 32'(dbg_state_o), 32'd0);

        // Full init sequence.
        for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, init_tab(i)});
        c0 = cmd_cnt;
        pulse_init();
        check("init_busy_set", 32'(init_busy), 32'd1);
        wait_init_clear("init_finish", 2000);
        check("init_done", 32'(init_done), 32'd1);
        check("init_error_clear", 32'(init_error), 32'd0);
        check("init_cmd_count", 32'(cmd_cnt - c0), 32'd10);
        check("init_no_reads", 32'(rd_cnt), 32'd0);
        check("init_queue_drained", 32'(exp_q.size()), 32'd0);

        // Host write then host read; the read issue respects the gap.
        wait_idle(100);
        exp_q.push_back({1'b0, 8'h12, 8'h5A});
        a0 = ack_cnt;
        host_txn(1'b1, 8'h12, 8'h5A);
        check("wr_ack_count", 32'(ack_cnt - a0), 32'd1);
        check("wr_err", 32'(last_err), 32'd0);
        check("wr_rdata_zero", 32'(last_rdata), 32'd0);
        ack1 = last_ack_cyc;

        model_give_valid = 1'b1;
        model_rd_data    = 8'hA3;
        exp_q.push_back({1'b1, 8'h07, 8'h00});
        host_txn(1'b0, 8'h07, 8'h00);
        check("gap_respected", 32'(last_issue_cyc - ack1 >= 16), 32'd1);
        check("rd_rdata", 32'(last_rdata), 32'hA3);
        check("rd_err", 32'(last_err), 32'd0);

        model_give_valid = 1'b0;
        exp_q.push_back({1'b1, 8'h07, 8'h00});
        a0 = ack_cnt;
        host_txn(1'b0, 8'h07, 8'h00);
        check("rd_novalid_err", 32'(last_err), 32'd1);
        check("rd_novalid_ack", 32'(ack_cnt - a0), 32'd1);
        check("host_reads", 32'(rd_cnt), 32'd2);

        // Controller silent on init entry 3: timeout aborts the sequence.
        wait_idle(100);
        model_stuck_at = model_cmd_n + 3;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, init_tab(i)});
        pulse_init();
        wait_init_clear("tmo_finish", 6000);
        t_err = cyc;
        diff  = t_err - last_issue_cyc;
        check("tmo_latency", 32'(diff >= 4096 && diff <= 4098), 32'd1);
        check("tmo_error", 32'(init_error), 32'd1);
        check("tmo_done", 32'(init_done), 32'd0);
        c0 = cmd_cnt;
        repeat (100) @(negedge clk);
        check("tmo_no_more_cmds", 32'(cmd_cnt - c0), 32'd0);

        model_stuck_at = -1;
        for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, init_tab(i)});
        pulse_init();
        check("restart_clears_error", 32'(init_error), 32'd0);
        check("restart_busy", 32'(init_busy), 32'd1);
        wait_init_clear("restart_finish", 2000);
        check("restart_done", 32'(init_done), 32'd1);
        check("restart_queue", 32'(exp_q.size()), 32'd0);

        // Same-cycle init_start and host_req: init first.
        wait_idle(100);
        for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, init_tab(i)});
        exp_q.push_back({1'b0, 8'h55, 8'h66});
        host_we    = 1'b1;
        host_addr  = 8'h55;
        host_wdata = 8'h66;
        host_req   = 1'b1;
        pulse_init();
        wait_ack("arb_ack_seen", 3000);
        host_req = 1'b0;
        check("arb_init_done_first", 32'(init_done), 32'd1);
        @(negedge clk);
        check("arb_queue", 32'(exp_q.size()), 32'd0);

        // init_start during a host command: host finishes first.
        wait_idle(100);
        exp_q.push_back({1'b0, 8'h21, 8'h43});
        for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, init_tab(i)});
        host_we    = 1'b1;
        host_addr  = 8'h21;
        host_wdata = 8'h43;
        host_req   = 1'b1;
        n = 0;
        while (dbg_state_o == 3'd0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        pulse_init();
        wait_ack("pre_ack_seen", 600);
        host_req = 1'b0;
        check("pre_init_pending", 32'(init_busy), 32'd1);
        wait_init_clear("pre_init_finish", 2000);
        check("pre_init_done", 32'(init_done), 32'd1);
        check("pre_queue", 32'(exp_q.size()), 32'd0);

        // Reset during WAIT_DONE.
        wait_idle(100);
        model_busy_len = 40;
        exp_q.push_back({1'b0, 8'h99, 8'h11});
        host_we    = 1'b1;
        host_addr  = 8'h99;
        host_wdata = 8'h11;
        host_req   = 1'b1;
        n = 0;
        while (dbg_state_o != 3'd3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_wait_done", 32'(dbg_state_o), 32'd3);
        reset = 1'b0;
        #1;
        check("mid_rst_enables", {30'd0, codec_wr_en, codec_rd_en}, 32'd0);
        check("mid_rst_addr_data", {16'd0, codec_reg_addr, codec_data_wr}, 32'd0);
        check("mid_rst_host", {23'd0, host_ack, host_rdata}, 32'd0);
        check("mid_rst_init_flags", {29'd0, init_busy, init_done, init_error}, 32'd0);
        check("mid_rst_state", 32'(dbg_state_o), 32'd0);
        host_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(dbg_state_o), 32'd0);
        check("post_rst_init_done", 32'(init_done), 32'd0);
        c0 = cmd_cnt;
        repeat (30) @(negedge clk);
        check("post_rst_quiet", 32'(cmd_cnt - c0), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
